serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle digit-serial subtractor: diff = a - b - bin. Each cycle one
//   DIGIT-wide slice is processed, LSB first, through a chain of gate-level
//   borrow cells. Sits beside the full-adder datapath as the subtraction
//   path for exponent/mantissa alignment. Valid/ready handshake on both sides.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   DIGIT   4  bits processed per cycle; WIDTH % DIGIT == 0 is required
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      a/b/bin valid
//   in_ready   out  1      block can accept an operation
//   a          in   WIDTH  minuend, unsigned or two's complement
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      unsigned borrow out: 1 iff a < b + bin
//   ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//   zero       out  1      diff == 0
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE; in_ready=1;
//     out_valid=0; diff=0; bout=0; ovf=0; zero=0; digit counter=0.
//   - FSM IDLE -> RUN -> DONE.
//     IDLE: in_ready=1. Accept on in_valid&&in_ready: latch a, b, and bin
//       into the running borrow; counter=0; -> RUN.
//     RUN: in_ready=0. Each cycle subtract slice [cnt*DIGIT +: DIGIT] using the
//       running borrow and write the slice into diff; the slice borrow-out
//       becomes the running borrow; cnt++. After the slice with
//       cnt == WIDTH/DIGIT-1 -> DONE.
//     DONE: out_valid=1; diff/bout/ovf/zero stable. On out_ready -> IDLE,
//       or straight back into RUN if in_valid is high in the same cycle.
//   - in_ready = (IDLE) || (DONE && out_ready). This gives back-to-back
//     throughput of one op per WIDTH/DIGIT+1 cycles.
//   - Latency: out_valid rises WIDTH/DIGIT cycles after the accept edge.
//   - bout = final running borrow. ovf uses the latched a/b MSBs. zero is
//     registered with the last slice.
//   - Outputs hold their values in IDLE until the next op finishes. out_valid
//     is deasserted in IDLE/RUN.
//   - Inputs are sampled only at acceptance; later changes are ignored.
//   - in_valid during RUN is ignored, with no side effect.
//   - out_ready outside DONE has no effect.
//   - rst mid-RUN or mid-DONE: immediate abort; all outputs go to their
//     reset values; the in-flight result is lost.
//   - WIDTH == DIGIT: RUN lasts exactly 1 cycle.
// STRUCTURE
//   - Shared package: FSM state encoding (IDLE/RUN/DONE as localparams).
//     The counter width is $clog2(WIDTH/DIGIT) (min 1).
//   - Sub-module full_subtractor(diff, bout, a, b, bin), gate-level:
//       diff = a^b^bin
//       bout = (~a&b) | (~(a^b)&bin)
//     Instantiate DIGIT copies in a generate loop as a ripple chain.
//   - Top level holds the operand registers, the digit mux, the running
//     borrow register, the result register, and the FSM.
// TESTING  (WIDTH=8, DIGIT=4 unless noted)
//   1. a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0, ovf=0, zero=0;
//      out_valid 2 cycles after accept.
//   2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
//      a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0.
//   3. a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
//      a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
//   4. Hold out_ready=0 for 5 cycles -> out_valid and diff stay stable and
//      in_ready=0. Then out_ready=1 with in_valid=1 in the same cycle -> the
//      next op is accepted that edge and its result arrives 2 cycles later.
//   5. Assert rst one cycle into RUN -> out_valid=0, diff=0, in_ready=1
//      asynchronously. A new op after release computes correctly.
//   6. WIDTH=32, DIGIT=32 and DIGIT=1: 1000 random ops vs a reference model
//      -> all fields match; latency is 1 and 32 cycles respectively.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and the digit-counter sizing helper.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = $clog2(width / digit);
    return (n < 32'sd1) ? 32'sd1 : n;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result bundle of the digit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit gate-level full subtractor; chained DIGIT-wide as a ripple borrow.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);
  logic axb_s;

  assign axb_s = a ^ b;
  assign diff  = axb_s ^ bin;
  assign bout  = (~a & b) | (~axb_s & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, one DIGIT-wide slice per cycle,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 32'sd1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r, diff_r, diff_next_s;
  logic [CW-1:0]    cnt_r;
  logic             borrow_r, bout_r, ovf_r, zero_r, out_valid_r;
  logic [DIGIT-1:0] a_dig_s, b_dig_s, d_dig_s;
  logic [DIGIT:0]   chain_s;
  logic             in_ready_s, last_s;

  assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
  assign last_s     = (cnt_r == CNT_LAST);
  assign chain_s[0] = borrow_r;

  // Select the active operand slice and splice its result digit into diff.
  always_comb begin
    a_dig_s     = a_r[int'(cnt_r) * DIGIT +: DIGIT];
    b_dig_s     = b_r[int'(cnt_r) * DIGIT +: DIGIT];
    diff_next_s = diff_r;
    diff_next_s[int'(cnt_r) * DIGIT +: DIGIT] = d_dig_s;
  end

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_subtractor u_fs (
      .diff (d_dig_s[i]),
      .bout (chain_s[i+1]),
      .a    (a_dig_s[i]),
      .b    (b_dig_s[i]),
      .bin  (chain_s[i])
    );
  end

  // Handshake FSM, operand capture and per-slice result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      diff_r      <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      borrow_r    <= 1'b0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            borrow_r <= bus.bin;
            cnt_r    <= CNT_ZERO;
            state_r  <= RUN;
          end
        end
        RUN: begin
          diff_r   <= diff_next_s;
          borrow_r <= chain_s[DIGIT];
          if (last_s) begin
            // The last slice carries the MSB, so sign and zero flags settle here.
            bout_r      <= chain_s[DIGIT];
            ovf_r       <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                           (d_dig_s[DIGIT-1] != a_r[WIDTH-1]);
            zero_r      <= (diff_next_s == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.in_valid) begin
              a_r      <= bus.a;
              b_r      <= bus.b;
              borrow_r <= bus.bin;
              cnt_r    <= CNT_ZERO;
              state_r  <= RUN;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
endmodule
